vga_scan_timing_gen: RTL and testbench

Produces the 640x480@60 Hz raster timing that drives the frame buffer controller and the display. It generates the free-running `counter_H`/`counter_V` pixel counters that the frame buffer controller consumes, plus HSYNC/VSYNC, a display-active flag, line and frame start strobes, and a tile/sub-tile/upscale decomposition of the current pixel. The decomposition uses the same 8-pixel tiles at x5 upscale (16x12 tile screen), so downstream blocks need no dividers. It sits between the clock/reset source and the frame buffer controller.

---
 rtl/vga_scan_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_scan_timing_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing_gen.sv
// Raster timing generator: free-running pixel/line counters, syncs, strobes and a
// divider-free tile/sub-tile/upscale decomposition of the current pixel.
module vga_scan_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 1,
    parameter int UPSCALE  = 5,
    parameter int TILE     = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] counter_H,
    output logic [9:0] counter_V,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [3:0] tile_h,
    output logic [3:0] tile_v,
    output logic [2:0] sub_col,
    output logic [2:0] sub_row,
    output logic [2:0] up_h,
    output logic [2:0] up_v
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS     = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS     = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0]  DIV_LAST  = 3'(CLK_DIV - 1);
    localparam logic [2:0]  UP_LAST   = 3'(UPSCALE - 1);
    localparam logic [2:0]  SUB_LAST  = 3'(TILE - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 8 ||
            UPSCALE < 1 || UPSCALE > 8 || TILE < 1 || TILE > 8) begin : g_param_check
            $error("vga_scan_timing_gen: parameter out of range");
        end
    endgenerate

    // Fields are packed as {tile[3:0], sub[2:0], up[2:0]}; one step moves one screen pixel.
    function automatic logic [9:0] step_fields(input logic [9:0] f);
        logic [3:0] t;
        logic [2:0] s;
        logic [2:0] u;
        {t, s, u} = f;
        if (u == UP_LAST) begin
            u = 3'd0;
            if (s == SUB_LAST) begin
                s = 3'd0;
                t = t + 4'd1;
            end else begin
                s = s + 3'd1;
            end
        end else begin
            u = u + 3'd1;
        end
        return {t, s, u};
    endfunction

    // Outside the visible span (and at position 0) the decomposition is forced to zero.
    function automatic logic [9:0] next_fields(input logic [9:0] f, input logic [9:0] pos,
                                               input logic [10:0] active);
        if (pos == 10'd0 || {1'b0, pos} >= active) begin
            return 10'd0;
        end
        return step_fields(f);
    endfunction

    function automatic logic in_window(input logic [9:0] pos, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

    logic [2:0] div;
    logic [2:0] div_p0;
    logic       adv_p0;
    logic       h_wrap_p0;
    logic [9:0] h_p0;
    logic [9:0] v_p0;
    logic [9:0] hf_p0;
    logic [9:0] vf_p0;
    logic       hsync_p0;
    logic       vsync_p0;
    logic       display_p0;
    logic       line_p0;
    logic       frame_p0;

    // Stage 0: next raster position and everything derived from it
    always_comb begin
        adv_p0     = (div == DIV_LAST);
        div_p0     = adv_p0 ? 3'd0 : div + 3'd1;
        h_wrap_p0  = (counter_H == H_LAST);
        h_p0       = h_wrap_p0 ? 10'd0 : counter_H + 10'd1;
        v_p0       = counter_V;
        vf_p0      = {tile_v, sub_row, up_v};
        if (h_wrap_p0) begin
            v_p0  = (counter_V == V_LAST) ? 10'd0 : counter_V + 10'd1;
            vf_p0 = next_fields({tile_v, sub_row, up_v}, v_p0, V_VIS);
        end
        hf_p0      = next_fields({tile_h, sub_col, up_h}, h_p0, H_VIS);
        hsync_p0   = !in_window(h_p0, HS_BEGIN, HS_END);
        vsync_p0   = !in_window(v_p0, VS_BEGIN, VS_END);
        display_p0 = ({1'b0, h_p0} < H_VIS) && ({1'b0, v_p0} < V_VIS);
        line_p0    = adv_p0 && (h_p0 == 10'd0);
        frame_p0   = line_p0 && (v_p0 == 10'd0);
    end

    // Stage 1: registered outputs, all taken from the same next position
    always_ff @(posedge clk) begin
        if (!reset) begin
            div         <= 3'd0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            counter_H   <= 10'd0;
            counter_V   <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b1;
            tile_h      <= 4'd0;
            sub_col     <= 3'd0;
            up_h        <= 3'd0;
            tile_v      <= 4'd0;
            sub_row     <= 3'd0;
            up_v        <= 3'd0;
        end else begin
            div         <= div_p0;
            pix_en      <= adv_p0;
            line_start  <= line_p0;
            frame_start <= frame_p0;
            if (adv_p0) begin
                counter_H                 <= h_p0;
                counter_V                 <= v_p0;
                hsync                     <= hsync_p0;
                vsync                     <= vsync_p0;
                display_on                <= display_p0;
                {tile_h, sub_col, up_h}   <= hf_p0;
                {tile_v, sub_row, up_v}   <= vf_p0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing_gen.sv
// Bench for vga_scan_timing_gen: three instances (full 640x480, short-line, tiny frame with
// CLK_DIV=2) checked every cycle against an arithmetic raster model plus literal expectations.
module tb_vga_scan_timing_gen;

    localparam int UPS = 5;
    localparam int TIL = 8;

    typedef struct packed {
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [3:0] th;
        logic [3:0] tv;
        logic [2:0] sc;
        logic [2:0] sr;
        logic [2:0] uh;
        logic [2:0] uv;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    logic reset_c = 1'b0;

    logic       a_pe, a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic [3:0] a_th, a_tv;
    logic [2:0] a_sc, a_sr, a_uh, a_uv;
    logic       b_pe, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    logic [3:0] b_th, b_tv;
    logic [2:0] b_sc, b_sr, b_uh, b_uv;
    logic       c_pe, c_hs, c_vs, c_de, c_ls, c_fs;
    logic [9:0] c_h, c_v;
    logic [3:0] c_th, c_tv;
    logic [2:0] c_sc, c_sr, c_uh, c_uv;

    obs_t a_obs, b_obs, c_obs;
    assign a_obs = {a_pe, a_h, a_v, a_hs, a_vs, a_de, a_ls, a_fs, a_th, a_tv, a_sc, a_sr, a_uh, a_uv};
    assign b_obs = {b_pe, b_h, b_v, b_hs, b_vs, b_de, b_ls, b_fs, b_th, b_tv, b_sc, b_sr, b_uh, b_uv};
    assign c_obs = {c_pe, c_h, c_v, c_hs, c_vs, c_de, c_ls, c_fs, c_th, c_tv, c_sc, c_sr, c_uh, c_uv};

    vga_scan_timing_gen dut_a (
        .clk(clk), .reset(reset_a), .pix_en(a_pe), .counter_H(a_h), .counter_V(a_v),
        .hsync(a_hs), .vsync(a_vs), .display_on(a_de), .line_start(a_ls), .frame_start(a_fs),
        .tile_h(a_th), .tile_v(a_tv), .sub_col(a_sc), .sub_row(a_sr), .up_h(a_uh), .up_v(a_uv)
    );

    vga_scan_timing_gen #(.H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2)) dut_b (
        .clk(clk), .reset(reset_b), .pix_en(b_pe), .counter_H(b_h), .counter_V(b_v),
        .hsync(b_hs), .vsync(b_vs), .display_on(b_de), .line_start(b_ls), .frame_start(b_fs),
        .tile_h(b_th), .tile_v(b_tv), .sub_col(b_sc), .sub_row(b_sr), .up_h(b_uh), .up_v(b_uv)
    );

    vga_scan_timing_gen #(.H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
                          .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(2)) dut_c (
        .clk(clk), .reset(reset_c), .pix_en(c_pe), .counter_H(c_h), .counter_V(c_v),
        .hsync(c_hs), .vsync(c_vs), .display_on(c_de), .line_start(c_ls), .frame_start(c_fs),
        .tile_h(c_th), .tile_v(c_tv), .sub_col(c_sc), .sub_row(c_sr), .up_h(c_uh), .up_v(c_uv)
    );

    // Clock edges since the last reset edge; the raster position follows from this alone.
    int n_a = 0;
    int n_b = 0;
    int n_c = 0;
    always @(posedge clk) begin
        n_a <= reset_a ? n_a + 1 : 0;
        n_b <= reset_b ? n_b + 1 : 0;
        n_c <= reset_c ? n_c + 1 : 0;
    end

    function automatic obs_t model(input int n, input int ha, input int hfp, input int hsw,
                                   input int hbp, input int va, input int vfp, input int vsw,
                                   input int vbp, input int dv);
        obs_t o;
        int ht, vt, pos, h, v;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        pos  = (n / dv) % (ht * vt);
        h    = pos % ht;
        v    = pos / ht;
        o    = '0;
        o.pe = (n > 0) && (n % dv == 0);
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.hs = !(h >= ha + hfp && h < ha + hfp + hsw);
        o.vs = !(v >= va + vfp && v < va + vfp + vsw);
        o.de = (h < ha) && (v < va);
        o.ls = o.pe && (h == 0);
        o.fs = o.ls && (v == 0);
        if (h < ha) begin
            o.uh = 3'(h % UPS);
            o.sc = 3'((h / UPS) % TIL);
            o.th = 4'(h / (UPS * TIL));
        end
        if (v < va) begin
            o.uv = 3'(v % UPS);
            o.sr = 3'((v / UPS) % TIL);
            o.tv = 4'(v / (UPS * TIL));
        end
        return o;
    endfunction

    int compared   = 0;
    int mismatched = 0;
    int printed    = 0;

    task automatic check(input string name, input int n, input logic [63:0] got,
                         input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            if (printed < 200) begin
                printed++;
                $display("FAIL %s at n=%0d: got %h, required %h", name, n, got, want);
            end
        end
    endtask

    bit chk_en     = 1'b0;
    bit c_rst_done = 1'b0;
    int hs_low     = 0;
    int ls_prev    = -1;
    int fs_b_cnt   = 0;
    int fs_b_first = -1;
    int fs_b_second = -1;
    int vs_lines   = 0;
    int vs_first   = -1;
    int fs_c_cnt   = 0;
    int fs_c_first = -1;
    int fs_c_second = -1;
    logic c_ls_prev = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("dut_a", n_a, 64'(a_obs), 64'(model(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 1)));
            check("dut_b", n_b, 64'(b_obs), 64'(model(n_b, 40, 2, 4, 2, 480, 10, 2, 33, 1)));
            check("dut_c", n_c, 64'(c_obs), 64'(model(n_c, 40, 2, 4, 2, 24, 2, 2, 2, 2)));

            if (n_a == 639) check("a_tile_639", n_a, 64'({a_th, a_sc, a_uh}), 64'({4'd15, 3'd7, 3'd4}));
            if (n_a == 640) check("a_tile_640", n_a, 64'({a_th, a_sc, a_uh, a_de}), 64'(0));
            if (n_a == 40)  check("a_tile_40", n_a, 64'({a_th, a_sc, a_uh}), 64'({4'd1, 3'd0, 3'd0}));
            if (n_b == 479 * 48 + 39)
                check("b_vtile_479", n_b, 64'({b_v, b_tv, b_sr, b_uv}),
                      64'({10'd479, 4'd11, 3'd7, 3'd4}));

            if (n_a == 799) hs_low = 0;
            if (n_a >= 800 && n_a < 1600 && !a_hs) hs_low++;
            if (n_a == 1600) check("a_hsync_width", n_a, 64'(hs_low), 64'(96));

            if (a_ls) begin
                if (ls_prev >= 0 && n_a > ls_prev) check("a_line_gap", n_a, 64'(n_a - ls_prev), 64'(800));
                ls_prev = n_a;
            end

            if (b_fs) begin
                fs_b_cnt++;
                if (fs_b_cnt == 1) fs_b_first = n_b;
                if (fs_b_cnt == 2) fs_b_second = n_b;
            end
            if (b_ls && n_b <= 25200 && !b_vs) begin
                vs_lines++;
                if (vs_first < 0) vs_first = int'(b_v);
            end

            if (c_fs && c_rst_done) begin
                fs_c_cnt++;
                if (fs_c_cnt == 1) fs_c_first = n_c;
                if (fs_c_cnt == 2) fs_c_second = n_c;
            end
            if (c_ls) check("c_strobe_single", n_c, 64'(c_ls_prev), 64'(0));
            c_ls_prev = c_ls;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("a_reset_state", 0, 64'(a_obs),
              64'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                   4'd0, 4'd0, 3'd0, 3'd0, 3'd0, 3'd0}));
        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;
        @(negedge clk);
        check("a_first_adv", n_a, 64'({a_pe, a_h}), 64'({1'b1, 10'd1}));
        check("c_first_edge", n_c, 64'({c_pe, c_h}), 64'({1'b0, 10'd0}));
        @(negedge clk);
        check("c_second_edge", n_c, 64'({c_pe, c_h}), 64'({1'b1, 10'd1}));

        // Mid-line, mid-frame reset of the full-size instance at (300, 2)
        for (int k = 0; k < 5000 && n_a != 1900; k++) @(negedge clk);
        check("a_pos_before_reset", n_a, 64'({a_h, a_v}), 64'({10'd300, 10'd2}));
        reset_a = 1'b0;
        @(negedge clk);
        check("a_after_reset", n_a, 64'({a_pe, a_h, a_v, a_hs, a_vs, a_ls, a_fs}),
              64'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
        reset_a = 1'b1;
        @(negedge clk);
        check("a_resume", n_a, 64'({a_pe, a_h, a_v}), 64'({1'b1, 10'd1, 10'd0}));

        // Same for the divided instance at (30, 20)
        for (int k = 0; k < 5000 && n_c != 1980; k++) @(negedge clk);
        check("c_pos_before_reset", n_c, 64'({c_h, c_v}), 64'({10'd30, 10'd20}));
        reset_c = 1'b0;
        @(negedge clk);
        check("c_after_reset", n_c, 64'({c_pe, c_h, c_v, c_hs, c_vs}),
              64'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1}));
        reset_c = 1'b1;
        c_rst_done = 1'b1;

        for (int k = 0; k < 60000 && n_b < 50410; k++) @(negedge clk);
        check("b_frame_first", n_b, 64'(fs_b_first), 64'(25200));
        check("b_frame_second", n_b, 64'(fs_b_second), 64'(50400));
        check("b_vsync_lines", n_b, 64'(vs_lines), 64'(2));
        check("b_vsync_first_line", n_b, 64'(vs_first), 64'(490));
        check("c_frame_first", n_c, 64'(fs_c_first), 64'(2880));
        check("c_frame_second", n_c, 64'(fs_c_second), 64'(5760));
        chk_en = 1'b0;
        if (printed < mismatched)
            $display("note: %0d further mismatch lines suppressed", mismatched - printed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
